// File: rtl/gpu_sram_pkg.sv
// Shared constants, address map and arbiter state type for the GPU SRAM port.
package gpu_sram_pkg;

  localparam int NUM_REQ         = 3;
  localparam int IDX_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ADDR_SIZE_BITS  = 24;
  localparam int WORD_SIZE_BYTES = 3;
  localparam int DATA_SIZE_WORDS = 64;
  localparam int DW              = 8 * WORD_SIZE_BYTES * DATA_SIZE_WORDS;

  // SRAM address map
  localparam logic [ADDR_SIZE_BITS-1:0] LAYER1_BASE = 24'd0;
  localparam logic [ADDR_SIZE_BITS-1:0] LAYER2_BASE = 24'd65536;
  localparam logic [ADDR_SIZE_BITS-1:0] TEX1_BASE   = 24'd131072;
  localparam logic [ADDR_SIZE_BITS-1:0] TEX2_BASE   = 24'd135168;
  localparam logic [ADDR_SIZE_BITS-1:0] TEX3_BASE   = 24'd139264;
  localparam logic [ADDR_SIZE_BITS-1:0] OUT_BASE    = 24'd143360;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Next requester index after idx, wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_REQ - 1)) begin
      return {IDX_W{1'b0}};
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: per-engine request/strobe/address/data
// plus the grant, broadcast read data and per-engine read-valid coming back.
interface sram_arbiter_if;
  import gpu_sram_pkg::*;

  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ-1:0]                req_read;
  logic [NUM_REQ-1:0]                req_write;
  logic [NUM_REQ*ADDR_SIZE_BITS-1:0] req_addr;
  logic [NUM_REQ*DW-1:0]             req_wdata;
  logic [NUM_REQ-1:0]                gnt;
  logic [DW-1:0]                     rdata;
  logic [NUM_REQ-1:0]                rvalid;

  modport master (
    output req, req_read, req_write, req_addr, req_wdata,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, req_read, req_write, req_addr, req_wdata,
    output gnt, rdata, rvalid
  );

endinterface

// File: rtl/sram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import gpu_sram_pkg::*;
#(
  parameter int N = NUM_REQ,
  parameter int W = IDX_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] pick,
  output logic [W-1:0] index,
  output logic         any
);

  int pos_s;

  // Scan requests starting at ptr and take the first one found.
  always_comb begin
    pick  = {N{1'b0}};
    index = {W{1'b0}};
    any   = 1'b0;
    pos_s = 0;
    for (int i = 0; i < N; i++) begin
      pos_s = int'(ptr) + i;
      if (pos_s >= N) begin
        pos_s = pos_s - N;
      end else begin
        pos_s = pos_s;
      end
      if (!any && req[pos_s]) begin
        any         = 1'b1;
        pick[pos_s] = 1'b1;
        index       = W'(pos_s);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin SRAM port arbiter with burst lock. The granted engine owns the
// port until it drops req; a one-cycle RELEASE turnaround follows each burst.
module sram_arbiter
  import gpu_sram_pkg::*;
(
  input  logic                      clk,
  input  logic                      n_rst,
  sram_arbiter_if.slave             bus,
  output logic                      conflict_err,
  output logic                      sram_read_enable,
  output logic                      sram_write_enable,
  output logic [ADDR_SIZE_BITS-1:0] sram_address,
  output logic [DW-1:0]             sram_write_data,
  input  logic [DW-1:0]             sram_read_data
);

  arb_state_t                state_r, state_nx_s;
  logic [NUM_REQ-1:0]        gnt_r, gnt_nx_s;
  logic [NUM_REQ-1:0]        rvalid_r;
  logic [IDX_W-1:0]          owner_r, owner_nx_s;
  logic [IDX_W-1:0]          rr_ptr_r, rr_ptr_nx_s;
  logic                      conflict_r;

  logic [NUM_REQ-1:0]        pick_s;
  logic [IDX_W-1:0]          pick_idx_s;
  logic                      pick_any_s;

  logic [NUM_REQ-1:0]        owner_oh_s;
  logic                      owner_req_s;
  logic                      owner_rd_s;
  logic                      owner_wr_s;
  logic [ADDR_SIZE_BITS-1:0] owner_addr_s;
  logic [DW-1:0]             owner_wdata_s;
  logic                      active_s;
  logic                      rd_fwd_s;

  rr_pick #(
    .N (NUM_REQ),
    .W (IDX_W)
  ) u_rr_pick (
    .req   (bus.req),
    .ptr   (rr_ptr_r),
    .pick  (pick_s),
    .index (pick_idx_s),
    .any   (pick_any_s)
  );

  assign bus.gnt      = gnt_r;
  assign bus.rvalid   = rvalid_r;
  assign bus.rdata    = sram_read_data;
  assign conflict_err = conflict_r;

  // Select the registered owner's request, strobes, address and data.
  always_comb begin
    owner_oh_s    = {NUM_REQ{1'b0}};
    owner_req_s   = 1'b0;
    owner_rd_s    = 1'b0;
    owner_wr_s    = 1'b0;
    owner_addr_s  = {ADDR_SIZE_BITS{1'b0}};
    owner_wdata_s = {DW{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_r == IDX_W'(i)) begin
        owner_oh_s[i] = 1'b1;
        owner_req_s   = bus.req[i];
        owner_rd_s    = bus.req_read[i];
        owner_wr_s    = bus.req_write[i];
        owner_addr_s  = bus.req_addr[i*ADDR_SIZE_BITS +: ADDR_SIZE_BITS];
        owner_wdata_s = bus.req_wdata[i*DW +: DW];
      end else begin
        owner_oh_s[i] = 1'b0;
      end
    end
  end

  // Next-state logic: grant on any request in IDLE, release when the owner drops req.
  always_comb begin
    state_nx_s  = state_r;
    gnt_nx_s    = gnt_r;
    owner_nx_s  = owner_r;
    rr_ptr_nx_s = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_nx_s = OWN;
          gnt_nx_s   = pick_s;
          owner_nx_s = pick_idx_s;
        end else begin
          state_nx_s = IDLE;
        end
      end
      OWN: begin
        if (!owner_req_s) begin
          state_nx_s  = RELEASE;
          gnt_nx_s    = {NUM_REQ{1'b0}};
          rr_ptr_nx_s = wrap_inc(owner_r);
        end else begin
          state_nx_s = OWN;
        end
      end
      RELEASE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
        gnt_nx_s   = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // SRAM steering: owner strobes only while it still holds req; write beats read.
  always_comb begin
    active_s          = (state_r == OWN) && owner_req_s;
    rd_fwd_s          = active_s && owner_rd_s && !owner_wr_s;
    sram_read_enable  = rd_fwd_s;
    sram_write_enable = active_s && owner_wr_s;
    if (state_r == OWN) begin
      sram_address    = owner_addr_s;
      sram_write_data = owner_wdata_s;
    end else begin
      sram_address    = {ADDR_SIZE_BITS{1'b0}};
      sram_write_data = {DW{1'b0}};
    end
  end

  // Arbitration state register: state, grant, owner and rotation pointer.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r  <= IDLE;
      gnt_r    <= {NUM_REQ{1'b0}};
      owner_r  <= {IDX_W{1'b0}};
      rr_ptr_r <= {IDX_W{1'b0}};
    end else begin
      state_r  <= state_nx_s;
      gnt_r    <= gnt_nx_s;
      owner_r  <= owner_nx_s;
      rr_ptr_r <= rr_ptr_nx_s;
    end
  end

  // Read-valid tagged with the issuing owner, and the sticky read/write conflict flag.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rvalid_r   <= {NUM_REQ{1'b0}};
      conflict_r <= 1'b0;
    end else begin
      rvalid_r   <= rd_fwd_s ? owner_oh_s : {NUM_REQ{1'b0}};
      conflict_r <= conflict_r | (active_s & owner_rd_s & owner_wr_s);
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus pushes expected grant changes,
// SRAM bus beats and read returns (with their cycle); a negedge monitor pops
// and compares whenever the DUT shows one of those outputs.
module tb_sram_arbiter;
  import gpu_sram_pkg::*;

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    int                 cyc;
  } gnt_exp_t;

  typedef struct {
    logic                      re;
    logic                      we;
    logic [ADDR_SIZE_BITS-1:0] addr;
    logic [DW-1:0]             wdata;
    int                        cyc;
  } bus_exp_t;

  typedef struct {
    logic [NUM_REQ-1:0] v;
    logic [DW-1:0]      data;
    int                 cyc;
  } rd_exp_t;

  logic                      clk;
  logic                      n_rst;
  logic                      conflict_err;
  logic                      sram_read_enable;
  logic                      sram_write_enable;
  logic [ADDR_SIZE_BITS-1:0] sram_address;
  logic [DW-1:0]             sram_write_data;
  logic [DW-1:0]             sram_read_data = '0;

  sram_arbiter_if bus ();

  sram_arbiter dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .bus               (bus),
    .conflict_err      (conflict_err),
    .sram_read_enable  (sram_read_enable),
    .sram_write_enable (sram_write_enable),
    .sram_address      (sram_address),
    .sram_write_data   (sram_write_data),
    .sram_read_data    (sram_read_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [NUM_REQ-1:0] prev_gnt = '0;

  gnt_exp_t gq[$];
  bus_exp_t bq[$];
  rd_exp_t  rq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rpat(input logic [ADDR_SIZE_BITS-1:0] a);
    logic [ADDR_SIZE_BITS-1:0] w;
    w = a ^ 24'h5A5A5A;
    return {DATA_SIZE_WORDS{w}};
  endfunction

  function automatic logic [DW-1:0] wpat(input int i);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(i);
    return {(DW/32){w}};
  endfunction

  // SRAM model: read data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (sram_read_enable) sram_read_data <= rpat(sram_address);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_gnt(input logic [NUM_REQ-1:0] g, input int c);
    gnt_exp_t e;
    e.gnt = g; e.cyc = c;
    gq.push_back(e);
  endtask

  task automatic push_bus(input logic re, input logic we, input logic [ADDR_SIZE_BITS-1:0] a,
                          input int r, input int c);
    bus_exp_t e;
    e.re = re; e.we = we; e.addr = a; e.wdata = wpat(r); e.cyc = c;
    bq.push_back(e);
  endtask

  task automatic push_rd(input logic [NUM_REQ-1:0] v, input logic [ADDR_SIZE_BITS-1:0] a,
                         input int c);
    rd_exp_t e;
    e.v = v; e.data = rpat(a); e.cyc = c;
    rq.push_back(e);
  endtask

  task automatic set_addr(input int r, input logic [ADDR_SIZE_BITS-1:0] a);
    bus.req_addr[r*ADDR_SIZE_BITS +: ADDR_SIZE_BITS] = a;
  endtask

  // Monitor: compare every grant change, SRAM strobe beat and read return.
  always @(negedge clk) begin
    gnt_exp_t ge;
    bus_exp_t be;
    rd_exp_t  re;
    if (mon_en) begin
      if (bus.gnt !== prev_gnt) begin
        checks++;
        if (gq.size() == 0) begin
          errors++;
          $display("FAIL gnt_unexpected: got %b at cycle %0d, required no change", bus.gnt, cyc);
        end else begin
          ge = gq.pop_front();
          if (bus.gnt !== ge.gnt || cyc != ge.cyc) begin
            errors++;
            $display("FAIL gnt: got %b at cycle %0d, required %b at cycle %0d",
                     bus.gnt, cyc, ge.gnt, ge.cyc);
          end
        end
      end
      prev_gnt = bus.gnt;

      if (sram_read_enable || sram_write_enable) begin
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL sram_unexpected: got re=%b we=%b addr=%h at cycle %0d, required no strobe",
                   sram_read_enable, sram_write_enable, sram_address, cyc);
        end else begin
          be = bq.pop_front();
          if (sram_read_enable !== be.re || sram_write_enable !== be.we ||
              sram_address !== be.addr || sram_write_data !== be.wdata || cyc != be.cyc) begin
            errors++;
            $display("FAIL sram_bus: got re=%b we=%b addr=%h wd=%h cyc=%0d, required re=%b we=%b addr=%h wd=%h cyc=%0d",
                     sram_read_enable, sram_write_enable, sram_address, sram_write_data[31:0], cyc,
                     be.re, be.we, be.addr, be.wdata[31:0], be.cyc);
          end
        end
      end

      if (bus.rvalid != '0) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected: got %b at cycle %0d, required 000", bus.rvalid, cyc);
        end else begin
          re = rq.pop_front();
          if (bus.rvalid !== re.v || bus.rdata !== re.data || cyc != re.cyc) begin
            errors++;
            $display("FAIL rvalid: got %b rdata=%h cyc=%0d, required %b rdata=%h cyc=%0d",
                     bus.rvalid, bus.rdata[31:0], cyc, re.v, re.data[31:0], re.cyc);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(bus.gnt), 64'd0);
    chk({tag, "_rvalid"}, 64'(bus.rvalid), 64'd0);
    chk({tag, "_conflict"}, 64'(conflict_err), 64'd0);
    chk({tag, "_strobes"}, 64'({sram_read_enable, sram_write_enable}), 64'd0);
    chk({tag, "_addr"}, 64'(sram_address), 64'd0);
    chk({tag, "_wdata_zero"}, 64'(sram_write_data == '0), 64'd1);
  endtask

  initial begin
    n_rst         = 1'b0;
    bus.req       = '0;
    bus.req_read  = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    for (int i = 0; i < NUM_REQ; i++) bus.req_wdata[i*DW +: DW] = wpat(i);

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    n_rst  = 1'b1;
    mon_en = 1'b1;
    tick(); tick();

    // 1: single read by requester 0
    bus.req = 3'b001; push_gnt(3'b001, cyc + 1); tick();
    bus.req_read[0] = 1'b1; set_addr(0, 24'h000040);
    push_bus(1'b1, 1'b0, 24'h000040, 0, cyc); push_rd(3'b001, 24'h000040, cyc + 1);
    tick();
    bus.req_read[0] = 1'b0; bus.req = 3'b000; push_gnt(3'b000, cyc + 1);
    tick(); tick(); tick();

    // 2: all requesting, strict rotation with RELEASE+IDLE gap
    n_rst = 1'b0; tick(); n_rst = 1'b1;
    bus.req = 3'b111; push_gnt(3'b001, cyc + 1); tick();
    for (int k = 0; k < 4; k++) begin
      int own;
      own = k % NUM_REQ;
      repeat (4) tick();
      if (k == 3) bus.req = 3'b000;
      else bus.req[own] = 1'b0;
      push_gnt(3'b000, cyc + 1); tick();
      if (k < 3) begin
        bus.req = 3'b111;
        push_gnt(3'b001 << ((k + 1) % NUM_REQ), cyc + 2);
      end
      tick(); tick();
    end

    // 3: non-owner write is ignored until requester 2 is granted
    bus.req = 3'b001; push_gnt(3'b001, cyc + 1); tick();
    bus.req[2] = 1'b1; bus.req_write[2] = 1'b1; set_addr(2, OUT_BASE);
    tick(); tick();
    bus.req[0] = 1'b0; push_gnt(3'b000, cyc + 1); tick();
    push_gnt(3'b100, cyc + 2); tick(); tick();
    push_bus(1'b0, 1'b1, OUT_BASE, 2, cyc);
    tick();
    bus.req_write[2] = 1'b0; bus.req[2] = 1'b0; push_gnt(3'b000, cyc + 1);
    tick(); tick(); tick();

    // 4: owner 1 read+write together -> write wins, sticky conflict
    chk("conflict_before", 64'(conflict_err), 64'd0);
    bus.req = 3'b010; push_gnt(3'b010, cyc + 1); tick();
    bus.req_read[1] = 1'b1; bus.req_write[1] = 1'b1; set_addr(1, LAYER2_BASE);
    push_bus(1'b0, 1'b1, LAYER2_BASE, 1, cyc);
    tick();
    bus.req_read[1] = 1'b0; bus.req_write[1] = 1'b0;
    chk("conflict_set", 64'(conflict_err), 64'd1);
    bus.req = 3'b000; push_gnt(3'b000, cyc + 1);
    tick(); tick(); tick();
    chk("conflict_sticky", 64'(conflict_err), 64'd1);
    n_rst = 1'b0; tick(); n_rst = 1'b1;
    chk("conflict_cleared", 64'(conflict_err), 64'd0);
    tick();

    // 5: last read of a burst, then a read in the req-drop cycle (not forwarded)
    bus.req = 3'b001; push_gnt(3'b001, cyc + 1); tick();
    bus.req_read[0] = 1'b1; set_addr(0, 24'h123456);
    push_bus(1'b1, 1'b0, 24'h123456, 0, cyc); push_rd(3'b001, 24'h123456, cyc + 1);
    tick();
    bus.req = 3'b000; set_addr(0, 24'h000777); push_gnt(3'b000, cyc + 1);
    tick();
    bus.req_read[0] = 1'b0;
    tick(); tick();

    // 6: reset mid-burst with a read outstanding; rvalid discarded, then regrant
    bus.req = 3'b100; push_gnt(3'b100, cyc + 1); tick();
    bus.req_read[2] = 1'b1; set_addr(2, 24'h0ABCDE);
    push_bus(1'b1, 1'b0, 24'h0ABCDE, 2, cyc);
    n_rst = 1'b0; push_gnt(3'b000, cyc + 1);
    tick();
    check_all_zero("midreset");
    bus.req_read[2] = 1'b0; n_rst = 1'b1; push_gnt(3'b100, cyc + 1);
    tick();
    bus.req = 3'b000; push_gnt(3'b000, cyc + 1);
    tick(); tick(); tick(); tick();

    // Every expected event must have been observed
    chk("gnt_queue_empty", 64'(gq.size()), 64'd0);
    chk("bus_queue_empty", 64'(bq.size()), 64'd0);
    chk("rd_queue_empty", 64'(rq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
